// File: rtl/btn_debounce_toggle.sv
// Push-button conditioner: 2-flop synchronizer, counting debounce FSM,
// one-cycle press strobe and a press-driven toggle level.

module btn_debounce_toggle #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       toggle_out,
  output logic [1:0] Estado
);

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  // The debounced level is high for the whole time the button is considered held.
  function automatic logic held_state(input state_t s);
    logic held;
    case (s)
      PRESSED:      held = 1'b1;
      RELEASE_WAIT: held = 1'b1;
      default:      held = 1'b0;
    endcase
    return held;
  endfunction

  logic             sync1_r;
  logic             sync2_r;
  logic             btn_s;
  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             accept_s;
  logic             btn_level_r;
  logic             press_pulse_r;
  logic             toggle_r;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  assign btn_s = sync2_r;

  // Debounce next-state and counter logic; >= keeps a corrupted count from stalling.
  always_comb begin
    state_next_s = IDLE;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (btn_s) begin
          state_next_s = PRESS_WAIT;
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next_s = IDLE;
        end else if (cnt_r >= CNT_MAX) begin
          state_next_s = PRESSED;
          accept_s     = 1'b1;
        end else begin
          state_next_s = PRESS_WAIT;
          cnt_next_s   = cnt_r + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_next_s = RELEASE_WAIT;
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = PRESSED;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_next_s = PRESSED;
        end else if (cnt_r >= CNT_MAX) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RELEASE_WAIT;
          cnt_next_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and registered outputs; level is decoded from the next state
  // so it lines up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= CNT_ZERO;
      btn_level_r   <= 1'b0;
      press_pulse_r <= 1'b0;
      toggle_r      <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      cnt_r         <= cnt_next_s;
      btn_level_r   <= held_state(state_next_s);
      press_pulse_r <= accept_s;
      if (accept_s) begin
        toggle_r <= ~toggle_r;
      end else begin
        toggle_r <= toggle_r;
      end
    end
  end

  assign btn_level   = btn_level_r;
  assign press_pulse = press_pulse_r;
  assign toggle_out  = toggle_r;
  assign Estado      = state_r;

  btn_debounce_toggle_chk #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .state       (state_r),
    .cnt         (cnt_r),
    .btn_level   (btn_level_r),
    .press_pulse (press_pulse_r),
    .toggle_out  (toggle_r)
  );

endmodule

// Run-time invariants of the debouncer: single-cycle strobe, toggle only on
// a strobe, level consistent with state, bounded counter.
module btn_debounce_toggle_chk #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input logic             clk,
  input logic             rst,
  input logic [1:0]       state,
  input logic [CNT_W-1:0] cnt,
  input logic             btn_level,
  input logic             press_pulse,
  input logic             toggle_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic pulse_q_r;
  logic toggle_q_r;

  // One-cycle history of strobe and toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_q_r  <= 1'b0;
      toggle_q_r <= 1'b0;
    end else begin
      pulse_q_r  <= press_pulse;
      toggle_q_r <= toggle_out;
    end
  end

  // Invariant checks, sampled before the edge updates.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(press_pulse && pulse_q_r));
      assert ((toggle_out == toggle_q_r) || press_pulse);
      assert (btn_level == state[1]);
      assert (cnt <= CNT_MAX);
    end
  end

endmodule

// File: tb/tb_btn_debounce_toggle.sv
// Directed bench for btn_debounce_toggle: a spec-level reference model pushes
// expected outputs per edge into a scoreboard queue, popped after each edge.

module tb_btn_debounce_toggle;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       btn_raw;
  logic       btn_level;
  logic       press_pulse;
  logic       toggle_out;
  logic [1:0] Estado;

  typedef struct packed {
    logic [1:0] st;
    logic       lvl;
    logic       pls;
    logic       tog;
  } exp_t;

  exp_t sbq[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses = 0;
  int pulse_edge = 0;
  int saw_wait = 0;

  // Reference model state (values after the most recent edge)
  int m_s1, m_s2, m_st, m_cnt, m_tog, m_pls;

  btn_debounce_toggle #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .press_pulse (press_pulse),
    .toggle_out  (toggle_out),
    .Estado      (Estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_st = 0; m_cnt = 0; m_tog = 0; m_pls = 0;
  endtask

  // One rising edge of the reference model, with btn_raw = raw at that edge.
  task automatic model_edge(input logic raw);
    int n_st, n_cnt;
    if (rst) begin
      model_reset();
      return;
    end
    n_st = m_st; n_cnt = m_cnt; m_pls = 0;
    if (m_st == 0) begin
      if (m_s2 == 1) begin n_st = 1; n_cnt = 0; end
    end else if (m_st == 1) begin
      if (m_s2 == 0) n_st = 0;
      else if (m_cnt == D - 1) begin n_st = 2; m_pls = 1; m_tog = 1 - m_tog; end
      else n_cnt = m_cnt + 1;
    end else if (m_st == 2) begin
      if (m_s2 == 0) begin n_st = 3; n_cnt = 0; end
    end else begin
      if (m_s2 == 1) n_st = 2;
      else if (m_cnt == D - 1) n_st = 0;
      else n_cnt = m_cnt + 1;
    end
    m_st = n_st; m_cnt = n_cnt;
    m_s2 = m_s1; m_s1 = int'(raw);
  endtask

  task automatic cycle(input logic raw, input string tag);
    exp_t e;
    btn_raw = raw;
    model_edge(raw);
    e.st  = 2'(m_st);
    e.lvl = (m_st >= 2);
    e.pls = m_pls[0];
    e.tog = m_tog[0];
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check({tag, ".Estado"},      int'(Estado),      int'(e.st));
    check({tag, ".btn_level"},   int'(btn_level),   int'(e.lvl));
    check({tag, ".press_pulse"}, int'(press_pulse), int'(e.pls));
    check({tag, ".toggle_out"},  int'(toggle_out),  int'(e.tog));
    if (press_pulse) pulses++;
    if (Estado == 2'b01 || Estado == 2'b11) saw_wait++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".Estado"},      int'(Estado),      0);
    check({tag, ".btn_level"},   int'(btn_level),   0);
    check({tag, ".press_pulse"}, int'(press_pulse), 0);
    check({tag, ".toggle_out"},  int'(toggle_out),  0);
  endtask

  initial begin
    rst = 1'b0;
    btn_raw = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1 check_all_zero("reset_init");

    // Reset held while the raw button chatters: nothing may leak through
    pulses = 0;
    for (int i = 0; i < 6; i++) cycle(1'(i & 1), "rst_chatter");
    check_all_zero("rst_chatter_end");
    check("rst_chatter.pulses", pulses, 0);

    // Clean press right after reset release: strobe exactly at edge D+3
    rst = 1'b0;
    pulses = 0;
    pulse_edge = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, "press");
      if (press_pulse) pulse_edge = i;
    end
    check("press.pulse_edge", pulse_edge, D + 3);
    check("press.pulses", pulses, 1);
    check("press.toggle", int'(toggle_out), 1);
    check("press.level", int'(btn_level), 1);
    check("press.Estado", int'(Estado), 2);

    // Short release glitch while pressed: back to PRESSED, no new strobe
    pulses = 0;
    saw_wait = 0;
    for (int i = 0; i < 2; i++) cycle(1'b0, "rel_glitch");
    for (int i = 0; i < 8; i++) cycle(1'b1, "rel_glitch");
    check("rel_glitch.pulses", pulses, 0);
    check("rel_glitch.saw_release_wait", int'(saw_wait > 0), 1);
    check("rel_glitch.Estado", int'(Estado), 2);

    // Full release
    for (int i = 0; i < 10; i++) cycle(1'b0, "release");
    check("release.Estado", int'(Estado), 0);
    check("release.level", int'(btn_level), 0);

    // Short press glitch: 3 cycles high, no strobe, toggle unchanged
    pulses = 0;
    saw_wait = 0;
    for (int i = 0; i < 3; i++) cycle(1'b1, "press_glitch");
    for (int i = 0; i < 8; i++) cycle(1'b0, "press_glitch");
    check("press_glitch.pulses", pulses, 0);
    check("press_glitch.saw_press_wait", int'(saw_wait > 0), 1);
    check("press_glitch.toggle", int'(toggle_out), 1);

    // Reset, then two full press/release sequences
    rst = 1'b1;
    cycle(1'b0, "rst2");
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) cycle(1'b1, "two_press.hi");
      check("two_press.level_hi", int'(btn_level), 1);
      check("two_press.toggle_mid", int'(toggle_out), (k == 0) ? 1 : 0);
      for (int i = 0; i < 8; i++) cycle(1'b0, "two_press.lo");
      check("two_press.level_lo", int'(btn_level), 0);
    end
    check("two_press.pulses", pulses, 2);
    check("two_press.toggle_end", int'(toggle_out), 0);

    // Asynchronous reset while in PRESS_WAIT
    for (int i = 0; i < 3; i++) cycle(1'b1, "abort");
    check("abort.Estado_before", int'(Estado), 1);
    rst = 1'b1;
    model_reset();
    #1 check_all_zero("abort_async");
    pulses = 0;
    cycle(1'b1, "abort_hold");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle(1'b0, "abort_after");
    check("abort.pulses", pulses, 0);
    check_all_zero("abort_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce_toggle.md
BTN_DEBOUNCE_TOGGLE -- requirements
Module: btn_debounce_toggle

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized cycles required to accept a level change; legal range 1..2^CNT_W.
REQ-002 Parameter CNT_W, default 16: debounce counter width.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous and active-high.
REQ-005 Port btn_raw  input  1: raw, asynchronous, bouncing push-button level; 1 = pressed.
REQ-006 Port btn_level  output reg  1: debounced button level.
REQ-007 Port press_pulse  output reg  1: one-cycle strobe on each accepted press.
REQ-008 Port toggle_out  output reg  1: level that flips on each accepted press; drives the downstream Moore FSM IN input.
REQ-009 Port Estado  output  2: current debounce state code.

Function
REQ-010 btn_raw SHALL pass through a 2-flop synchronizer (sync1, then sync2); btn_s = sync2 SHALL be the only form of the button used by the FSM.
REQ-011 State encoding SHALL be IDLE=2'b00, PRESS_WAIT=2'b01, PRESSED=2'b10, RELEASE_WAIT=2'b11; Estado SHALL equal the state register.
REQ-012 In IDLE: btn_s=1 SHALL cause a move to PRESS_WAIT with cnt<=0; otherwise the block stays in IDLE.
REQ-013 In PRESS_WAIT: btn_s=0 SHALL cause a return to IDLE with no output change; btn_s=1 with cnt==DEBOUNCE_CYCLES-1 SHALL cause a move to PRESSED; otherwise cnt SHALL increment.
REQ-014 In PRESSED: btn_s=0 SHALL cause a move to RELEASE_WAIT with cnt<=0; otherwise the block stays in PRESSED.
REQ-015 In RELEASE_WAIT: btn_s=1 SHALL cause a return to PRESSED with no pulse; btn_s=0 with cnt==DEBOUNCE_CYCLES-1 SHALL cause a move to IDLE; otherwise cnt SHALL increment.
REQ-016 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL hold its value in IDLE and PRESSED.
REQ-017 On the edge that takes PRESS_WAIT->PRESSED: press_pulse<=1 and toggle_out<=~toggle_out; on every other edge press_pulse<=0.
REQ-018 btn_level SHALL be registered: 1 while the state is PRESSED or RELEASE_WAIT, 0 otherwise (Moore).
REQ-019 Latency: with btn_raw stable high, press_pulse SHALL rise at the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge that samples btn_raw=1 into sync1 as edge 1.
REQ-020 A glitch on btn_raw shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse, no toggle and no btn_level change.
REQ-021 press_pulse SHALL never be high on two consecutive cycles; each press/release sequence yields at most one pulse.
REQ-022 An unreachable or illegal state value SHALL recover to IDLE on the next edge.

Reset
REQ-023 While rst=1, independent of clk: state=IDLE, cnt=0, sync1=sync2=0, btn_level=0, press_pulse=0, toggle_out=0, Estado=2'b00.
REQ-024 Reset asserted mid-operation (any state) SHALL abort immediately; no pulse is generated for the interrupted press.
REQ-025 A button held across reset release SHALL be treated as a new press and accepted per REQ-019.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 rst=1 with btn_raw toggling -> all outputs 0 and Estado=00 throughout; no pulse.
REQ-027 Reset released, btn_raw=1 held for 12 cycles -> press_pulse high exactly at edge 7 for one cycle, toggle_out 0->1, btn_level=1, Estado=10.
REQ-028 btn_raw high 3 cycles then low -> Estado 00->01->00, no pulse, toggle_out unchanged.
REQ-029 In PRESSED, btn_raw low 2 cycles then high -> Estado 10->11->10, btn_level stays 1, no second pulse.
REQ-030 Two full press/release sequences, each level held 8 cycles -> exactly two pulses, toggle_out 0->1->0, btn_level tracks each press.
REQ-031 rst pulsed while Estado=01 -> Estado=00 and all outputs 0 immediately, before the next clk edge; no pulse follows.
